asteroids_input: RTL and testbench

ASTEROIDS_INPUT -- requirements
Module: asteroids_input

---
 rtl/asteroids_input_if.sv | 10 +
 rtl/asteroids_input.sv | 142 ++++++++++++++
 tb/tb_asteroids_input.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asteroids_input_if.sv
// Bundles the keyboard event word, the joystick word and the active-low button
// outputs between the input decoder and its environment.
interface asteroids_input_if;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic [7:0]  buttons_l;

  modport master (output ps2_key, output joy, input buttons_l);
  modport slave  (input ps2_key, input joy, output buttons_l);
endinterface

// File: rtl/asteroids_input.sv
// Turns PS/2 key events and joystick bits into the arcade cabinet's active-low
// button vector, with SOCD cleaning on left/right and a fixed-length coin pulse.
module asteroids_input #(
  parameter int unsigned COIN_CYCLES = 2500000
) (
  input  logic        clk_25,
  input  logic        reset,
  asteroids_input_if.slave bus
);

  localparam logic [21:0] COIN_LOAD = 22'(COIN_CYCLES - 1);

  logic        old_tog_q;
  logic [15:0] joy_q;
  logic [7:0]  buttons_l_q, buttons_l_d;

  // One state bit per physical key so that releasing one duplicate never
  // cancels a function still held by another.
  logic [1:0]  fire_q,   fire_d;
  logic [1:0]  start1_q, start1_d;
  logic [1:0]  start2_q, start2_d;
  logic [1:0]  left_q,   left_d;
  logic [1:0]  right_q,  right_d;
  logic [2:0]  coin_q,   coin_d;
  logic [1:0]  thrust_q, thrust_d;
  logic [1:0]  shield_q, shield_d;

  logic [21:0] coin_cnt_q, coin_cnt_d;
  logic        coin_src_q;

  logic        key_evt;
  logic        key_press;
  logic [8:0]  key_code;

  logic        f_right, f_left, f_start1, f_start2, f_fire, f_thrust, f_shield;
  logic        socd;
  logic        coin_src, coin_start, coin_act;
  logic        unused_joy;

  assign key_evt   = (bus.ps2_key[10] != old_tog_q) && !reset;
  assign key_press = bus.ps2_key[9];
  assign key_code  = bus.ps2_key[8:0];

  always_comb begin
    fire_d   = fire_q;
    start1_d = start1_q;
    start2_d = start2_q;
    left_d   = left_q;
    right_d  = right_q;
    coin_d   = coin_q;
    thrust_d = thrust_q;
    shield_d = shield_q;
    if (key_evt) begin
      case (key_code)
        9'h03A:  fire_d[0]   = key_press;
        9'h014:  fire_d[1]   = key_press;
        9'h005:  start1_d[0] = key_press;
        9'h016:  start1_d[1] = key_press;
        9'h006:  start2_d[0] = key_press;
        9'h01E:  start2_d[1] = key_press;
        9'h01C:  left_d[0]   = key_press;
        9'h023:  right_d[0]  = key_press;
        9'h004:  coin_d[0]   = key_press;
        9'h02E:  coin_d[1]   = key_press;
        9'h036:  coin_d[2]   = key_press;
        9'h04B:  thrust_d[0] = key_press;
        9'h011:  thrust_d[1] = key_press;
        9'h042:  shield_d[0] = key_press;
        9'h029:  shield_d[1] = key_press;
        default: ;
      endcase
      // Cursor keys arrive with or without the extended prefix.
      if (key_code[7:0] == 8'h6B) left_d[1]  = key_press;
      if (key_code[7:0] == 8'h74) right_d[1] = key_press;
    end
  end

  assign f_right  = (|right_q)  | joy_q[0];
  assign f_left   = (|left_q)   | joy_q[1];
  assign f_fire   = (|fire_q)   | joy_q[4];
  assign f_thrust = (|thrust_q) | joy_q[5];
  assign f_shield = (|shield_q) | joy_q[6];
  assign f_start1 = (|start1_q) | joy_q[7];
  assign f_start2 = |start2_q;
  assign socd     = f_left & f_right;

  assign unused_joy = ^{joy_q[15:8], joy_q[3:2]};

  // A pulse starts only on a fresh rising edge while idle; holding the key or
  // re-pressing mid-pulse never stretches or retriggers it.
  assign coin_src   = |coin_q;
  assign coin_start = coin_src & ~coin_src_q & (coin_cnt_q == 22'd0);
  assign coin_act   = coin_start | (coin_cnt_q != 22'd0);

  always_comb begin
    coin_cnt_d = coin_cnt_q;
    if (coin_start) begin
      coin_cnt_d = COIN_LOAD;
    end else if (coin_cnt_q != 22'd0) begin
      coin_cnt_d = coin_cnt_q - 22'd1;
    end
  end

  always_comb begin
    buttons_l_d = ~{f_right & ~socd, f_left & ~socd, f_start1, f_start2,
                    f_fire, coin_act, f_thrust, f_shield};
  end

  always_ff @(posedge clk_25) begin
    old_tog_q <= bus.ps2_key[10];
    if (reset) begin
      joy_q       <= '0;
      fire_q      <= '0;
      start1_q    <= '0;
      start2_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      coin_q      <= '0;
      thrust_q    <= '0;
      shield_q    <= '0;
      coin_cnt_q  <= '0;
      coin_src_q  <= 1'b0;
      buttons_l_q <= 8'hFF;
    end else begin
      joy_q       <= bus.joy;
      fire_q      <= fire_d;
      start1_q    <= start1_d;
      start2_q    <= start2_d;
      left_q      <= left_d;
      right_q     <= right_d;
      coin_q      <= coin_d;
      thrust_q    <= thrust_d;
      shield_q    <= shield_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_src_q  <= coin_src;
      buttons_l_q <= buttons_l_d;
    end
  end

  assign bus.buttons_l = buttons_l_q;

endmodule

// File: tb/tb_asteroids_input.sv
// Directed bench for asteroids_input: key decode, duplicates, SOCD, joystick
// latency, coin pulse shaping and reset behaviour, with COIN_CYCLES = 4.
module tb_asteroids_input;

  logic clk_25 = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  asteroids_input_if bus ();

  asteroids_input #(.COIN_CYCLES(4)) dut (
    .clk_25 (clk_25),
    .reset  (reset),
    .bus    (bus)
  );

  always #20 clk_25 = ~clk_25;

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic key(input logic [8:0] code, input logic press);
    bus.ps2_key = {~bus.ps2_key[10], press, code};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ps2_key = 11'h400;
    bus.joy = 16'h0000;
    tick(); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_hold: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    reset = 1'b0;
    tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_release: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
  endtask

  task automatic test_fire();
    key(9'h03A, 1'b1);
    tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL fire_latency: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    tick();
    vectors++;
    if (bus.buttons_l !== 8'hF7) begin
      miscompares++;
      $display("FAIL fire_press: buttons_l=%h expected %h", bus.buttons_l, 8'hF7);
    end
    key(9'h03A, 1'b0);
    tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL fire_release: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
  endtask

  task automatic test_duplicates();
    key(9'h03A, 1'b1); tick(); tick();
    key(9'h014, 1'b1); tick(); tick();
    key(9'h03A, 1'b0); tick(); tick();
    vectors++;
    if (bus.buttons_l[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL dup_hold: buttons_l[3]=%b expected 0", bus.buttons_l[3]);
    end
    tick(); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hF7) begin
      miscompares++;
      $display("FAIL dup_hold_later: buttons_l=%h expected %h", bus.buttons_l, 8'hF7);
    end
    key(9'h014, 1'b0); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL dup_release: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
  endtask

  task automatic test_socd();
    key(9'h16B, 1'b1);
    bus.joy = 16'h0001;
    tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL socd_both: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    key(9'h16B, 1'b0); tick(); tick();
    vectors++;
    if (bus.buttons_l[7:6] !== 2'b01) begin
      miscompares++;
      $display("FAIL socd_right_only: buttons_l[7:6]=%b expected 01", bus.buttons_l[7:6]);
    end
    bus.joy = 16'h0000;
    key(9'h06B, 1'b1); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hBF) begin
      miscompares++;
      $display("FAIL left_noext: buttons_l=%h expected %h", bus.buttons_l, 8'hBF);
    end
    key(9'h06B, 1'b0); tick();
    key(9'h174, 1'b1); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'h7F) begin
      miscompares++;
      $display("FAIL right_ext: buttons_l=%h expected %h", bus.buttons_l, 8'h7F);
    end
    key(9'h174, 1'b0); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL right_release: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
  endtask

  task automatic test_unmapped();
    key(9'h07E, 1'b1); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL unmapped_07e: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    key(9'h11C, 1'b1); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL ext_11c_not_left: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    key(9'h07E, 1'b0); tick();
    key(9'h11C, 1'b0); tick();
    bus.joy = 16'h00F0;
    tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL joy_latency: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    tick();
    vectors++;
    if (bus.buttons_l !== 8'hD4) begin
      miscompares++;
      $display("FAIL joy_f0: buttons_l=%h expected %h", bus.buttons_l, 8'hD4);
    end
    bus.joy = 16'h0000;
    tick(); tick();
  endtask

  task automatic test_same_cycle();
    key(9'h03A, 1'b1);
    bus.joy = 16'h0002;
    tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL same_cycle_latency: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    tick();
    vectors++;
    if (bus.buttons_l !== 8'hB7) begin
      miscompares++;
      $display("FAIL same_cycle: buttons_l=%h expected %h", bus.buttons_l, 8'hB7);
    end
    key(9'h03A, 1'b0);
    bus.joy = 16'h0000;
    tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL same_cycle_clear: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
  endtask

  task automatic test_coin();
    int zeros, first, last;
    zeros = 0; first = 0; last = 0;
    key(9'h02E, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 2) key(9'h004, 1'b1);
      if (bus.buttons_l[2] === 1'b0) begin
        zeros++;
        if (first == 0) first = i;
        last = i;
      end
    end
    vectors++;
    if (zeros !== 4) begin
      miscompares++;
      $display("FAIL coin_len: low cycles=%0d expected 4", zeros);
    end
    vectors++;
    if (first !== 2 || last !== 5) begin
      miscompares++;
      $display("FAIL coin_window: first=%0d last=%0d expected 2..5", first, last);
    end
    key(9'h02E, 1'b0); tick();
    key(9'h004, 1'b0); tick(); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL coin_idle: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    zeros = 0; first = 0; last = 0;
    key(9'h036, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.buttons_l[2] === 1'b0) begin
        zeros++;
        if (first == 0) first = i;
        last = i;
      end
    end
    vectors++;
    if (zeros !== 4 || first !== 2 || last !== 5) begin
      miscompares++;
      $display("FAIL coin_second: low=%0d first=%0d last=%0d expected 4 at 2..5",
               zeros, first, last);
    end
    key(9'h036, 1'b0); tick(); tick();
  endtask

  task automatic test_reset_mid_pulse();
    int bad;
    bad = 0;
    key(9'h016, 1'b1); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hDF) begin
      miscompares++;
      $display("FAIL start1_held: buttons_l=%h expected %h", bus.buttons_l, 8'hDF);
    end
    key(9'h02E, 1'b1); tick(); tick();
    vectors++;
    if (bus.buttons_l !== 8'hDB) begin
      miscompares++;
      $display("FAIL coin_with_start1: buttons_l=%h expected %h", bus.buttons_l, 8'hDB);
    end
    reset = 1'b1;
    key(9'h004, 1'b1);
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.buttons_l !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_mid_pulse: buttons_l=%h expected %h", bus.buttons_l, 8'hFF);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.buttons_l !== 8'hFF) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: cycles not FF=%0d expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_fire();
    test_duplicates();
    test_socd();
    test_unmapped();
    test_same_cycle();
    test_coin();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
